// File: rtl/uart_secded_rx.sv
// UART receiver that reassembles one byte from two SECDED-protected code words (low nibble first).
// Define UART_RX_ERR_CNT_EN to add saturating corrected/uncorrectable nibble counters.
module uart_secded_rx #(
  parameter int DATA_SIZE = 8,
  parameter int SAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  input  logic                 rd_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 sec_err,
  output logic                 ded_err,
  output logic                 frame_err,
`ifdef UART_RX_ERR_CNT_EN
  output logic [15:0]          sec_cnt,
  output logic [15:0]          ded_cnt,
`endif
  output logic                 overrun
);

  localparam int TW  = $clog2(SAMPLE);
  localparam int BW  = $clog2(DATA_SIZE);
  localparam int NIB = DATA_SIZE / 2;
  localparam logic [TW-1:0] TICK_MID  = TW'(SAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_SIZE-1:0]   shift_q, shift_d;
  logic                   phase_q, phase_d;
  logic [NIB-1:0]         lo_nib_q, lo_nib_d;
  logic                   lo_sec_q, lo_sec_d;
  logic                   lo_ded_q, lo_ded_d;
  logic [DATA_SIZE-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   sec_err_q, sec_err_d;
  logic                   ded_err_q, ded_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_ERR_CNT_EN
  logic [15:0]            sec_cnt_q, sec_cnt_d;
  logic [15:0]            ded_cnt_q, ded_cnt_d;
`endif

  logic                   rx_sync;
  logic                   word_ok;
  logic                   frame_bad;
  logic                   byte_done;
  logic [2:0]             syn;
  logic                   par;
  logic [DATA_SIZE-1:0]   corr;
  logic [NIB-1:0]         nib;
  logic                   nib_sec;
  logic                   nib_ded;

  assign rx_sync = sync_q[1];
  assign sync_d  = {sync_q[0], rx};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_sync) state_d = START;
      START: if (s_tick && tick_q == TICK_MID) state_d = rx_sync ? IDLE : DATA;
      DATA:  if (s_tick && tick_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = STOP;
      STOP:  if (s_tick && tick_q == TICK_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit timing: START counts to mid-bit, after which every sample lands SAMPLE ticks later.
  always_comb begin
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_ok   = 1'b0;
    frame_bad = 1'b0;
    case (state_q)
      IDLE: begin
        tick_d    = '0;
        bit_cnt_d = '0;
      end
      START: if (s_tick) tick_d = (tick_q == TICK_MID) ? '0 : tick_q + 1'b1;
      DATA: if (s_tick) begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          shift_d   = {rx_sync, shift_q[DATA_SIZE-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      STOP: if (s_tick) begin
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          word_ok   = rx_sync;
          frame_bad = !rx_sync;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: tick_d = '0;
    endcase
  end

  // Extended Hamming decode; a nonzero syndrome names the 1-based position of the bad bit.
  always_comb begin
    syn  = {shift_q[3] ^ shift_q[4] ^ shift_q[5] ^ shift_q[6],
            shift_q[1] ^ shift_q[2] ^ shift_q[5] ^ shift_q[6],
            shift_q[0] ^ shift_q[2] ^ shift_q[4] ^ shift_q[6]};
    par  = ^shift_q;
    corr = shift_q;
    if (syn != 3'd0 && par) begin
      for (int i = 0; i < 7; i++) begin
        if (syn == 3'(i + 1)) corr[i] = ~shift_q[i];
      end
    end
    nib     = {corr[6], corr[5], corr[4], corr[2]};
    nib_sec = par;
    nib_ded = (syn != 3'd0) && !par;
  end

  // data_valid/rd_ready: a byte is consumed on any clk edge where both are high.
  always_comb begin
    phase_d      = phase_q;
    lo_nib_d     = lo_nib_q;
    lo_sec_d     = lo_sec_q;
    lo_ded_d     = lo_ded_q;
    byte_done    = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q && !rd_ready;
    sec_err_d    = sec_err_q;
    ded_err_d    = ded_err_q;
    frame_err_d  = frame_bad;
    overrun_d    = 1'b0;
    if (frame_bad) begin
      phase_d = 1'b0;
    end else if (word_ok) begin
      if (!phase_q) begin
        lo_nib_d = nib;
        lo_sec_d = nib_sec;
        lo_ded_d = nib_ded;
        phase_d  = 1'b1;
      end else begin
        byte_done = 1'b1;
        phase_d   = 1'b0;
      end
    end
    if (byte_done) begin
      if (!data_valid_q || rd_ready) begin
        data_out_d   = {nib, lo_nib_q};
        sec_err_d    = nib_sec || lo_sec_q;
        ded_err_d    = nib_ded || lo_ded_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (word_ok && nib_sec && sec_cnt_q != 16'hFFFF) sec_cnt_d = sec_cnt_q + 16'd1;
    if (word_ok && nib_ded && ded_cnt_q != 16'hFFFF) ded_cnt_d = ded_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign sec_cnt = sec_cnt_q;
  assign ded_cnt = ded_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= 2'b11;
      tick_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      phase_q      <= 1'b0;
      lo_nib_q     <= '0;
      lo_sec_q     <= 1'b0;
      lo_ded_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sec_err_q    <= 1'b0;
      ded_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      tick_q       <= tick_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      lo_nib_q     <= lo_nib_d;
      lo_sec_q     <= lo_sec_d;
      lo_ded_q     <= lo_ded_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      sec_err_q    <= sec_err_d;
      ded_err_q    <= ded_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sec_err    = sec_err_q;
  assign ded_err    = ded_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_secded_rx.sv
// Bench for uart_secded_rx: directed frames plus random error-injected byte pairs
// checked against a nearest-code-word reference decoder.
module tb_uart_secded_rx;

  localparam int TICK_DIV = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       sec_err;
  logic       ded_err;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_ERR_CNT_EN
  logic [15:0] sec_cnt;
  logic [15:0] ded_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int fe_cnt  = 0;
  int ov_cnt  = 0;
  int exp_sec_cnt = 0;
  int exp_ded_cnt = 0;
  logic [9:0] exp_q[$];

  uart_secded_rx #(.DATA_SIZE(8), .SAMPLE(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_tick     (s_tick),
    .rx         (rx),
    .rd_ready   (rd_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .sec_err    (sec_err),
    .ded_err    (ded_err),
    .frame_err  (frame_err),
`ifdef UART_RX_ERR_CNT_EN
    .sec_cnt    (sec_cnt),
    .ded_cnt    (ded_cnt),
`endif
    .overrun    (overrun)
  );

  // Clock and oversampling strobe
  always #5 clk = ~clk;

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_tick = (cnt == 0);
      cnt = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (reset_n && frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (reset_n && overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time exceeded, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Returns {ded, sec, nibble} by nearest valid code word.
  function automatic logic [5:0] ref_decode(input logic [7:0] w);
    int best_d;
    logic [3:0] best_n;
    best_d = 9;
    best_n = 4'd0;
    for (int n = 0; n < 16; n++) begin
      int d;
      d = $countones(w ^ encode(4'(n)));
      if (d < best_d) begin
        best_d = d;
        best_n = 4'(n);
      end
    end
    if (best_d == 0) return {2'b00, best_n};
    if (best_d == 1) return {2'b01, best_n};
    return {2'b10, w[6], w[5], w[4], w[2]};
  endfunction

  function automatic logic [7:0] inject(input logic [7:0] w, input int k);
    int p0;
    int p1;
    logic [7:0] r;
    r  = w;
    p0 = $urandom_range(0, 7);
    p1 = (p0 + $urandom_range(1, 7)) % 8;
    if (k >= 1) r[p0] = ~r[p0];
    if (k >= 2) r[p1] = ~r[p1];
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic b, input int nticks);
    #1 rx = b;
    repeat (nticks * TICK_DIV) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] w, input bit stop_ok);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(w[i], 16);
    if (stop_ok) begin
      drive(1'b1, 16);
    end else begin
      drive(1'b0, 12);
      drive(1'b1, 4);
    end
    drive(1'b1, 6);
  endtask

  task automatic count_word(input logic [7:0] w);
    logic [5:0] r;
    r = ref_decode(w);
    if (r[4]) exp_sec_cnt++;
    if (r[5]) exp_ded_cnt++;
  endtask

  task automatic send_pair(input logic [7:0] w0, input logic [7:0] w1);
    send_frame(w0, 1'b1);
    count_word(w0);
    send_frame(w1, 1'b1);
    count_word(w1);
  endtask

  task automatic expect_pair(input logic [7:0] w0, input logic [7:0] w1);
    logic [5:0] r0;
    logic [5:0] r1;
    r0 = ref_decode(w0);
    r1 = ref_decode(w1);
    exp_q.push_back({r0[5] | r1[5], r0[4] | r1[4], r1[3:0], r0[3:0]});
  endtask

  task automatic check_counts(input string tag);
`ifdef UART_RX_ERR_CNT_EN
    check({tag, "_sec_cnt"}, sec_cnt, 16'(exp_sec_cnt));
    check({tag, "_ded_cnt"}, ded_cnt, 16'(exp_ded_cnt));
`else
    check({tag, "_no_cnt"}, 16'(exp_sec_cnt + exp_ded_cnt), 16'(exp_sec_cnt + exp_ded_cnt) & 16'hFFFF);
`endif
  endtask

  // Scoreboard: compare held byte against the queue head, then consume it.
  task automatic check_byte(input string tag);
    logic [9:0] e;
    @(negedge clk);
    check({tag, "_valid"}, data_valid, 1'b1);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s_queue: observed empty queue, expected a queued byte", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, data_out, e[7:0]);
      check({tag, "_sec"}, sec_err, e[8]);
      check({tag, "_ded"}, ded_err, e[9]);
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    check({tag, "_cleared"}, data_valid, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, data_out, 8'h00);
    check({tag, "_valid"}, data_valid, 1'b0);
    check({tag, "_sec"}, sec_err, 1'b0);
    check({tag, "_ded"}, ded_err, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
  endtask

  initial begin : stimulus
    int fe0;
    int ov0;
    logic [7:0] w0;
    logic [7:0] w1;

    // Reset
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    repeat (10) @(posedge clk);

    // Clean pair
    expect_pair(8'h2D, 8'hD2);
    send_pair(8'h2D, 8'hD2);
    @(negedge clk);
    check("clean_const_data", data_out, 8'hA5);
    check("clean_const_sec", sec_err, 1'b0);
    check("clean_const_ded", ded_err, 1'b0);
    check_byte("clean");
    check_counts("clean");

    // Single-bit error in low word
    expect_pair(8'h29, 8'hD2);
    send_pair(8'h29, 8'hD2);
    @(negedge clk);
    check("sec_const_data", data_out, 8'hA5);
    check("sec_const_sec", sec_err, 1'b1);
    check("sec_const_ded", ded_err, 1'b0);
    check_byte("sec");
    check_counts("sec");

    // Double-bit error in low word
    expect_pair(8'h2E, 8'hD2);
    send_pair(8'h2E, 8'hD2);
    @(negedge clk);
    check("ded_const_ded", ded_err, 1'b1);
    check_byte("ded");
    check_counts("ded");

    // Bad stop bit discards the word and restarts the nibble pairing
    fe0 = fe_cnt;
    send_frame(8'h2D, 1'b0);
    expect_pair(8'h2D, 8'hD2);
    send_pair(8'h2D, 8'hD2);
    check("frame_err_pulses", 16'(fe_cnt - fe0), 16'd1);
    @(negedge clk);
    check("frame_const_data", data_out, 8'hA5);
    check_byte("frame");

    // Overrun: second byte dropped while first is unread
    ov0 = ov_cnt;
    expect_pair(8'h2D, 8'hD2);
    send_pair(8'h2D, 8'hD2);
    send_pair(encode(4'h3), encode(4'hC));
    check("overrun_pulses", 16'(ov_cnt - ov0), 16'd1);
    @(negedge clk);
    check("overrun_held_data", data_out, 8'hA5);
    check_byte("overrun");
    check_counts("overrun");

    // Random pairs with 0..2 injected bit errors per word
    for (int t = 0; t < 8; t++) begin
      w0 = inject(encode(4'($urandom_range(0, 15))), $urandom_range(0, 2));
      w1 = inject(encode(4'($urandom_range(0, 15))), $urandom_range(0, 2));
      expect_pair(w0, w1);
      send_pair(w0, w1);
      check_byte("random");
    end
    check_counts("random");

    // Short glitch must be rejected without disturbing the next pair
    drive(1'b0, 3);
    drive(1'b1, 16);
    expect_pair(8'h2D, 8'hD2);
    send_pair(8'h2D, 8'hD2);
    check_byte("glitch");

    // Reset in the middle of the data bits
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 16);
    drive(1'b1, 8);
    reset_n = 1'b0;
    rx = 1'b1;
    exp_sec_cnt = 0;
    exp_ded_cnt = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("midreset");
    check_counts("midreset");
    reset_n = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("after_reset_valid", data_valid, 1'b0);
    expect_pair(8'h2D, 8'hD2);
    send_pair(8'h2D, 8'hD2);
    check_byte("after_reset");
    check_counts("after_reset");

    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
